// File: rtl/bcd_seg7_scan_if.sv
// Bus between the modulo-N counter and the BCD display stage.
// Signals:
//   DIN  - unsigned binary value to display (IN_WIDTH bits)
//   LOAD - strobe; sample DIN this cycle
//   BUSY - conversion in progress
//   DONE - one-cycle pulse when the display register updates
//   AN   - active-low one-hot digit enables, AN[0] is units
//   SEG  - active-low segments {g,f,e,d,c,b,a}
// Modports: master drives DIN/LOAD, slave (the display stage) drives the rest.
interface bcd_seg7_scan_if #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned DIGITS   = 4
);
    logic [IN_WIDTH-1:0] DIN;
    logic                LOAD;
    logic                BUSY;
    logic                DONE;
    logic [DIGITS-1:0]   AN;
    logic [6:0]          SEG;

    modport master (output DIN, output LOAD, input BUSY, input DONE, input AN, input SEG);
    modport slave  (input DIN, input LOAD, output BUSY, output DONE, output AN, output SEG);
endinterface

// File: rtl/bcd_seg7_scan.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock)
// feeding a time-multiplexed active-low 7-segment digit scanner.
// Ports:
//   CLK - system clock, rising edge
//   RST - synchronous active-low reset
//   bus - bcd_seg7_scan_if.slave (DIN, LOAD in; BUSY, DONE, AN, SEG out)
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks digits above the
// most significant non-zero digit (digit 0 is never blanked).
module bcd_seg7_scan #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic              CLK,
    input  logic              RST,
    bcd_seg7_scan_if.slave    bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // True when every IN_WIDTH-bit value fits in DIGITS decimal digits.
    function automatic bit range_ok();
        longint unsigned lim = 64'd1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (lim <= (64'd1 << 59)) lim = lim * 64'd10;
        end
        return (IN_WIDTH <= 62) && ((64'd1 << IN_WIDTH) <= lim);
    endfunction

    if (!range_ok()) begin : g_bad_range
        $error("bcd_seg7_scan: IN_WIDTH too wide for DIGITS");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("bcd_seg7_scan: SCAN_DIV must be at least 2");
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d, adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [IN_WIDTH-1:0] pend_val_q, pend_val_d;
    logic [BCD_W-1:0]    disp_q, disp_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Converter next-state and datapath.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        disp_d     = disp_q;
        done_d     = 1'b0;
        adj        = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (bus.LOAD) begin
                    shift_d   = bus.DIN;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_WIDTH - 1)) state_d = COMMIT;
                if (bus.LOAD) begin
                    pend_d     = 1'b1;
                    pend_val_d = bus.DIN;
                end
            end
            COMMIT: begin
                disp_d = scratch_q;
                done_d = 1'b1;
                // A LOAD coinciding with COMMIT is newer than any pending value.
                if (bus.LOAD || pend_q) begin
                    shift_d   = bus.LOAD ? bus.DIN : pend_val_q;
                    scratch_d = '0;
                    cnt_d     = '0;
                    pend_d    = 1'b0;
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Converter state register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            disp_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            disp_q     <= disp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        nib;
`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0]  msd;
`endif

    // Scanner: prescaler, digit index and segment decode.
    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        an_d = '1;
        nib  = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                an_d[i] = 1'b0;
                nib     = disp_q[4*i +: 4];
            end
        end
        seg_d = seg_decode(nib);
`ifdef LEADING_ZERO_BLANK_EN
        msd = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (disp_q[4*i +: 4] != 4'd0) msd = IDX_W'(i);
        end
        if (idx_q > msd) seg_d = 7'b1111111;
`endif
    end

    // Scanner registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= 7'b1111111;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.AN   = an_q;
    assign bus.SEG  = seg_q;
endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Directed bench for bcd_seg7_scan (IN_WIDTH=8, DIGITS=4, SCAN_DIV=4).
module tb_bcd_seg7_scan;
    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    bcd_seg7_scan_if #(.IN_WIDTH(8), .DIGITS(4)) bus ();

    bcd_seg7_scan #(.IN_WIDTH(8), .DIGITS(4), .SCAN_DIV(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Expected pattern for decimal digit d of val.
    function automatic logic [6:0] exp_seg(input int val, input int d);
        int p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && val < p) return 7'b1111111;
`endif
        return SEG_TAB[(val / p) % 10];
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input int v);
        bus.DIN  = 8'(v);
        bus.LOAD = 1'b1;
        step();
        bus.LOAD = 1'b0;
    endtask

    // Waits for a 0111->1110 wrap, then records one full 16-cycle scan frame.
    task automatic capture_scan(output bit ok, output logic [63:0] an_v, output logic [111:0] seg_v);
        logic [3:0] prev;
        ok = 1'b0;
        an_v = '0;
        seg_v = '0;
        for (int c = 0; c < 64; c++) begin
            prev = bus.AN;
            step();
            if (prev == 4'b0111 && bus.AN == 4'b1110) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            for (int i = 0; i < 16; i++) begin
                an_v[4*i +: 4]  = bus.AN;
                seg_v[7*i +: 7] = bus.SEG;
                step();
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        bus.LOAD = 1'b0;
        bus.DIN = '0;
        repeat (3) step();
        checks++; if (bus.AN !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", bus.AN); end
        checks++; if (bus.SEG !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b want 1111111", bus.SEG); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.DONE); end
        RST = 1'b1;
        step();
        checks++; if (bus.AN !== 4'b1110) begin errors++; $display("FAIL release_an got %b want 1110", bus.AN); end
        checks++; if (bus.SEG !== 7'b1000000) begin errors++; $display("FAIL release_seg got %b want 1000000", bus.SEG); end
    endtask

    task automatic test_latency();
        int busy_cnt = 0, done_cnt = 0, done_cyc = -1;
        bit ok;
        logic [63:0] an_v;
        logic [111:0] seg_v;
        logic [3:0] ea;
        load(123);
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL busy_rise got %b want 1", bus.BUSY); end
        busy_cnt = 1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.BUSY === 1'b1) busy_cnt++;
            if (bus.DONE === 1'b1) begin done_cnt++; done_cyc = c; end
        end
        checks++; if (busy_cnt != 9) begin errors++; $display("FAIL busy_len got %0d want 9", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_count got %0d want 1", done_cnt); end
        checks++; if (done_cyc != 9) begin errors++; $display("FAIL done_latency got %0d want 9", done_cyc); end
        capture_scan(ok, an_v, seg_v);
        checks++; if (!ok) begin errors++; $display("FAIL scan_sync_123 got none want 0111->1110 wrap"); end
        for (int i = 0; i < 16 && ok; i++) begin
            ea = ~(4'b0001 << (i / 4));
            checks++;
            if (an_v[4*i +: 4] !== ea || seg_v[7*i +: 7] !== exp_seg(123, i / 4)) begin
                errors++;
                $display("FAIL scan_123[%0d] got %b/%b want %b/%b", i, an_v[4*i +: 4], seg_v[7*i +: 7], ea, exp_seg(123, i / 4));
            end
        end
    endtask

    task automatic test_values();
        int vals [3] = '{255, 0, 7};
        bit seen, ok;
        logic [63:0] an_v;
        logic [111:0] seg_v;
        logic [3:0] ea;
        foreach (vals[n]) begin
            load(vals[n]);
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                step();
                if (bus.DONE === 1'b1) seen = 1'b1;
            end
            checks++; if (!seen) begin errors++; $display("FAIL done_%0d got none want pulse", vals[n]); end
            capture_scan(ok, an_v, seg_v);
            checks++; if (!ok) begin errors++; $display("FAIL scan_sync_%0d got none want wrap", vals[n]); end
            for (int i = 0; i < 16 && ok; i++) begin
                ea = ~(4'b0001 << (i / 4));
                checks++;
                if (an_v[4*i +: 4] !== ea || seg_v[7*i +: 7] !== exp_seg(vals[n], i / 4)) begin
                    errors++;
                    $display("FAIL scan_%0d[%0d] got %b/%b want %b/%b", vals[n], i, an_v[4*i +: 4], seg_v[7*i +: 7], ea, exp_seg(vals[n], i / 4));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0, first = -1, second = -1;
        bit ok;
        logic [63:0] an_v;
        logic [111:0] seg_v;
        logic [3:0] ea;
        load(10);
        step();
        load(20);
        load(30);
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.DONE === 1'b1) begin
                done_cnt++;
                if (first < 0) first = c; else second = c;
            end
        end
        checks++; if (done_cnt != 2) begin errors++; $display("FAIL pend_done_count got %0d want 2", done_cnt); end
        checks++; if (second - first != 9) begin errors++; $display("FAIL pend_gap got %0d want 9", second - first); end
        capture_scan(ok, an_v, seg_v);
        checks++; if (!ok) begin errors++; $display("FAIL scan_sync_30 got none want wrap"); end
        for (int i = 0; i < 16 && ok; i++) begin
            ea = ~(4'b0001 << (i / 4));
            checks++;
            if (an_v[4*i +: 4] !== ea || seg_v[7*i +: 7] !== exp_seg(30, i / 4)) begin
                errors++;
                $display("FAIL scan_30[%0d] got %b/%b want %b/%b", i, an_v[4*i +: 4], seg_v[7*i +: 7], ea, exp_seg(30, i / 4));
            end
        end
    endtask

    task automatic test_abort();
        int done_cnt = 0, busy_cnt = 0;
        bit ok;
        logic [63:0] an_v;
        logic [111:0] seg_v;
        logic [3:0] ea;
        load(99);
        bus.DIN = 8'd55;
        bus.LOAD = 1'b1;
        step();
        bus.LOAD = 1'b0;
        step();
        step();
        RST = 1'b0;
        step();
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", bus.DONE); end
        RST = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.DONE === 1'b1) done_cnt++;
            if (bus.BUSY === 1'b1) busy_cnt++;
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL abort_pending got %0d busy cycles want 0", busy_cnt); end
        capture_scan(ok, an_v, seg_v);
        checks++; if (!ok) begin errors++; $display("FAIL scan_sync_abort got none want wrap"); end
        for (int i = 0; i < 16 && ok; i++) begin
            ea = ~(4'b0001 << (i / 4));
            checks++;
            if (an_v[4*i +: 4] !== ea || seg_v[7*i +: 7] !== exp_seg(0, i / 4)) begin
                errors++;
                $display("FAIL scan_abort[%0d] got %b/%b want %b/%b", i, an_v[4*i +: 4], seg_v[7*i +: 7], ea, exp_seg(0, i / 4));
            end
        end
    endtask

    task automatic test_mod10();
        int cnt10 = 0, exp_val = 0, shown = -1, done_cnt = 0, run = 0;
        bit checked = 1'b1, first = 1'b1;
        logic [3:0] prev_an;
        prev_an = bus.AN;
        for (int cyc = 0; cyc < 120; cyc++) begin
            bus.DIN  = 8'(cnt10);
            bus.LOAD = (cyc % 20 == 0);
            if (bus.LOAD) exp_val = cnt10;
            step();
            bus.LOAD = 1'b0;
            if (cyc % 3 == 0) cnt10 = (cnt10 + 1) % 10;
            if (bus.DONE === 1'b1) begin
                done_cnt++;
                shown = exp_val;
                checked = 1'b0;
            end else if (!checked && bus.AN == 4'b1110) begin
                checked = 1'b1;
                checks++;
                if (bus.SEG !== exp_seg(shown, 0)) begin
                    errors++;
                    $display("FAIL mod10_units got %b want %b (value %0d)", bus.SEG, exp_seg(shown, 0), shown);
                end
            end
            if (bus.AN != prev_an) begin
                if (!first) begin
                    checks++;
                    if (run != 4 || bus.AN != {prev_an[2:0], prev_an[3]}) begin
                        errors++;
                        $display("FAIL slot_seq got %b after %b run %0d want %b run 4", bus.AN, prev_an, run, {prev_an[2:0], prev_an[3]});
                    end
                end
                first = 1'b0;
                run = 1;
            end else begin
                run++;
            end
            prev_an = bus.AN;
        end
        checks++; if (done_cnt != 6) begin errors++; $display("FAIL mod10_done_count got %0d want 6", done_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_values();
        test_back_to_back();
        test_abort();
        test_mod10();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
